// File: rtl/init_clear_seq.sv
// Power-on clear sequencer: waits for first_done, writes FILL to every register-file
// entry one per cycle, settles, then reports ready and counts completed passes.
module init_clear_seq #(
  parameter int             DEPTH      = 16,
  parameter int             AW         = 4,
  parameter int             DW         = 8,
  parameter logic [DW-1:0]  FILL       = '0,
  parameter int             SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          first_done,
  input  logic          soft_clr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          ready,
  output logic          clr_done,
  output logic [3:0]    pass_cnt
);

  localparam int            SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_WAIT, S_CLEAR, S_SETTLE, S_READY} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [SW-1:0] scnt, scnt_nx;
  logic [3:0]    pcnt, pcnt_nx;
  logic          done, done_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
      addr  <= '0;
      scnt  <= '0;
      pcnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      scnt  <= scnt_nx;
      pcnt  <= pcnt_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    scnt_nx  = scnt;
    pcnt_nx  = pcnt;
    done_nx  = 1'b0;
    case (state)
      S_WAIT: begin
        if (first_done) begin
          state_nx = S_CLEAR;
          addr_nx  = '0;
        end
      end
      S_CLEAR: begin
        // compare against DEPTH-1, not the AW wrap, so short files stop early
        if (addr == LAST) begin
          state_nx = S_SETTLE;
          addr_nx  = '0;
          scnt_nx  = '0;
        end else begin
          addr_nx  = addr + AW'(1);
        end
      end
      S_SETTLE: begin
        if (scnt == SLAST) begin
          state_nx = S_READY;
          done_nx  = 1'b1;
          pcnt_nx  = (pcnt == 4'hF) ? pcnt : pcnt + 4'd1;
        end else begin
          scnt_nx  = scnt + SW'(1);
        end
      end
      S_READY: begin
        if (soft_clr) begin
          state_nx = S_CLEAR;
          addr_nx  = '0;
        end
      end
      default: state_nx = S_WAIT;
    endcase
  end

  assign wr_en    = (state == S_CLEAR);
  assign wr_addr  = addr;
  assign wr_data  = FILL;
  assign busy     = (state == S_CLEAR) || (state == S_SETTLE);
  assign ready    = (state == S_READY);
  assign clr_done = done;
  assign pass_cnt = pcnt;

endmodule

// File: tb/tb_init_clear_seq.sv
// Directed bench for init_clear_seq: expected write addresses are queued when a pass
// is triggered and popped as the DUT writes; a 16-deep and a 10-deep instance run.
module tb_init_clear_seq;
  logic clk = 1'b0;
  logic rst;
  logic fd, sc, fd2, sc2;

  logic       a_wr_en, a_busy, a_ready, a_clr_done;
  logic [3:0] a_wr_addr, a_pass;
  logic [7:0] a_wr_data;
  logic       b_wr_en, b_busy, b_ready, b_clr_done;
  logic [3:0] b_wr_addr, b_pass;
  logic [7:0] b_wr_data;

  int ncmp = 0;
  int nerr = 0;
  int q1[$];
  int q2[$];
  int n;

  always #5 clk = ~clk;

  init_clear_seq #(.DEPTH(16), .AW(4), .DW(8), .FILL(8'h00), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .first_done(fd), .soft_clr(sc),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .busy(a_busy),
    .ready(a_ready), .clr_done(a_clr_done), .pass_cnt(a_pass));

  init_clear_seq #(.DEPTH(10), .AW(4), .DW(8), .FILL(8'h00), .SETTLE_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .first_done(fd2), .soft_clr(sc2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy),
    .ready(b_ready), .clr_done(b_clr_done), .pass_cnt(b_pass));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push1();
    for (int i = 0; i < 16; i++) q1.push_back(i);
  endtask

  task automatic push2();
    for (int i = 0; i < 10; i++) q2.push_back(i);
  endtask

  task automatic wait_rdy1(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (a_ready) break;
    end
    if (!a_ready) chk("a_ready_timeout", a_ready, 1);
  endtask

  task automatic wait_rdy2(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (b_ready) break;
    end
    if (!b_ready) chk("b_ready_timeout", b_ready, 1);
  endtask

  task automatic wait_addr1(input int a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_wr_en && a_wr_addr == 4'(a)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("a_addr_timeout", a_wr_addr, a);
  endtask

  // write scoreboard and structural invariants, sampled just after each edge
  always begin
    @(posedge clk);
    #1;
    if (a_wr_en) begin
      if (q1.size() == 0) chk("a_extra_wr", a_wr_en, 0);
      else chk("a_wr_addr", a_wr_addr, q1.pop_front());
    end
    if (b_wr_en) begin
      if (q2.size() == 0) chk("b_extra_wr", b_wr_en, 0);
      else chk("b_wr_addr", b_wr_addr, q2.pop_front());
      chk("b_addr_range", b_wr_addr < 4'd10, 1);
    end
    chk("a_rdy_and_busy", a_ready & a_busy, 0);
    chk("a_wren_not_busy", a_wr_en & ~a_busy, 0);
    chk("b_rdy_and_busy", b_ready & b_busy, 0);
    chk("a_wr_data", a_wr_data, 0);
  end

  initial begin
    rst = 1'b1; fd = 1'b0; sc = 1'b0; fd2 = 1'b0; sc2 = 1'b0;
    #2;
    chk("rst_wr_en", a_wr_en, 0);
    chk("rst_wr_addr", a_wr_addr, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_clr_done", a_clr_done, 0);
    chk("rst_pass", a_pass, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle in WAIT with soft_clr pulses: nothing should happen
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      sc  = (i % 7 == 3);
      sc2 = sc;
    end
    sc = 1'b0; sc2 = 1'b0;
    @(negedge clk);
    chk("idle_ready", a_ready, 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_pass", a_pass, 0);

    // first pass
    push1();
    fd = 1'b1;
    @(negedge clk);
    chk("p1_wr_en", a_wr_en, 1);
    chk("p1_addr0", a_wr_addr, 0);
    chk("p1_busy", a_busy, 1);
    wait_rdy1(n);
    chk("p1_latency", n, 18);
    chk("p1_clr_done", a_clr_done, 1);
    chk("p1_pass", a_pass, 1);
    @(negedge clk);
    chk("p1_clr_done_width", a_clr_done, 0);
    chk("p1_ready_hold", a_ready, 1);
    chk("p1_q_empty", q1.size(), 0);

    // soft re-clear; a soft_clr mid-pass must not queue another
    push1();
    sc = 1'b1;
    @(negedge clk);
    sc = 1'b0;
    chk("p2_wr_en", a_wr_en, 1);
    chk("p2_ready_low", a_ready, 0);
    wait_addr1(7);
    sc = 1'b1;
    @(negedge clk);
    sc = 1'b0;
    wait_rdy1(n);
    chk("p2_pass", a_pass, 2);
    chk("p2_clr_done", a_clr_done, 1);
    @(negedge clk);
    chk("p2_no_requeue", a_ready, 1);
    chk("p2_no_write", a_wr_en, 0);
    chk("p2_q_empty", q1.size(), 0);

    // asynchronous reset mid-pass
    push1();
    sc = 1'b1;
    @(negedge clk);
    sc = 1'b0;
    wait_addr1(9);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", a_wr_en, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_pass", a_pass, 0);
    chk("arst_addr", a_wr_addr, 0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    push1();
    wait_rdy1(n);
    chk("arst_relat", n, 19);
    chk("arst_pass1", a_pass, 1);
    chk("arst_q_empty", q1.size(), 0);

    // soft_clr held high: back-to-back passes, saturating count
    sc = 1'b1;
    for (int p = 2; p <= 21; p++) begin
      push1();
      @(negedge clk);
      chk("sat_ready_1cyc", a_ready, 0);
      chk("sat_busy", a_busy, 1);
      wait_rdy1(n);
      chk("sat_pass", a_pass, (p > 15) ? 15 : p);
      chk("sat_clr_done", a_clr_done, 1);
    end
    sc = 1'b0;
    @(negedge clk);
    chk("sat_stay_ready", a_ready, 1);
    chk("sat_clr_done_low", a_clr_done, 0);
    chk("sat_q_empty", q1.size(), 0);

    // short register file
    push2();
    fd2 = 1'b1;
    @(negedge clk);
    chk("d10_wr_en", b_wr_en, 1);
    wait_rdy2(n);
    chk("d10_latency", n, 12);
    chk("d10_pass", b_pass, 1);
    chk("d10_clr_done", b_clr_done, 1);
    chk("d10_q_empty", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
